// File: rtl/vga_pkg.sv
// Shared VGA constants, colours and the menu selection state type.
// Used by draw_menu_anim, menu_sel_ctrl and their bench.
package vga_pkg;

    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;

    localparam logic [11:0] COLOR_BLACK      = 12'h000;
    localparam logic [11:0] COLOR_DARK_GREEN = 12'h050;
    localparam logic [11:0] COLOR_DARK_BROWN = 12'h420;
    localparam logic [11:0] MENU_BG_COLOR    = 12'h224;
    localparam logic [11:0] COLOR_MENU_SEL   = 12'h48C;

    typedef enum logic [1:0] {
        IDLE,
        PEND_UP,
        PEND_DN
    } sel_state_t;

    // Two-colour border pattern: green on the upper half-period.
    function automatic logic [11:0] border_color(input logic green);
        return green ? COLOR_DARK_GREEN : COLOR_DARK_BROWN;
    endfunction

endpackage

// File: rtl/vga_if.sv
// VGA timing plus rgb bundle.
// Modports: in (consumer side), out (producer side).
interface vga_if;

    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;

    modport in (
        input vcount, vsync, vblnk,
        input hcount, hsync, hblnk,
        input rgb
    );

    modport out (
        output vcount, vsync, vblnk,
        output hcount, hsync, hblnk,
        output rgb
    );

endinterface

// File: rtl/menu_sel_ctrl.sv
// Menu selection FSM: buttons arm a pending move, applied on a frame tick.
// Ports: clk, rst, tick, btn_up, btn_down -> sel_idx, sel_changed (pulse).
module menu_sel_ctrl
    import vga_pkg::*;
#(
    parameter int N_ITEMS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick,
    input  logic                       btn_up,
    input  logic                       btn_down,
    output logic [$clog2(N_ITEMS)-1:0] sel_idx,
    output logic                       sel_changed
);

    localparam int SW = $clog2(N_ITEMS);
    localparam logic [SW-1:0] LAST = SW'(N_ITEMS - 1);

    sel_state_t state, state_nxt, base;
    logic [SW-1:0] sel_nxt;
    logic          chg_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sel_idx     <= '0;
            sel_changed <= 1'b0;
        end else begin
            state       <= state_nxt;
            sel_idx     <= sel_nxt;
            sel_changed <= chg_nxt;
        end
    end

    always_comb begin
        sel_nxt   = sel_idx;
        chg_nxt   = 1'b0;
        base      = state;
        state_nxt = state;

        // A tick commits the pending move; any button this cycle then
        // sees the FSM as already idle.
        if (tick && state != IDLE) begin
            chg_nxt = 1'b1;
            base    = IDLE;
            if (state == PEND_UP)
                sel_nxt = (sel_idx == '0) ? LAST : sel_idx - SW'(1);
            else
                sel_nxt = (sel_idx == LAST) ? '0 : sel_idx + SW'(1);
        end

        state_nxt = base;
        // Simultaneous presses are ignored, so only act on exactly one.
        if (btn_up ^ btn_down) begin
            unique case (base)
                IDLE:    state_nxt = btn_up ? PEND_UP : PEND_DN;
                PEND_UP: state_nxt = btn_down ? IDLE : PEND_UP;
                PEND_DN: state_nxt = btn_up ? IDLE : PEND_DN;
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/draw_menu_anim.sv
// Menu overlay: scrolling two-colour border, selection highlight band.
// Ports: clk, rst, in/out (vga_if), btn_up, btn_down, sel_idx, sel_changed.
// Macro MENU_SCROLL_EN enables the border scroll animation.
module draw_menu_anim
    import vga_pkg::*;
#(
    parameter int BORDER_W   = 16,
    parameter int TILE       = 16,
    parameter int N_ITEMS    = 4,
    parameter int ITEM_Y0    = 200,
    parameter int ITEM_H     = 64,
    parameter int SCROLL_DIV = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    vga_if.in                          in,
    vga_if.out                         out,
    input  logic                       btn_up,
    input  logic                       btn_down,
    output logic [$clog2(N_ITEMS)-1:0] sel_idx,
    output logic                       sel_changed
);

    localparam int OW = $clog2(2 * TILE);
    localparam logic [OW-1:0] TILE_V = OW'(TILE);

    localparam logic [10:0] LO_EDGE  = 11'(BORDER_W);
    localparam logic [10:0] BOT_EDGE = 11'(VER_PIXELS - BORDER_W);
    localparam logic [10:0] RGT_EDGE = 11'(HOR_PIXELS - BORDER_W);

    // Band arithmetic width covers the end of the last item band.
    localparam int YMAX = ITEM_Y0 + N_ITEMS * ITEM_H;
    localparam int YW   = $clog2(YMAX + 1);
    localparam int CW   = (YW > 11) ? YW : 11;

    if (SCROLL_DIV < 1) begin : g_bad_div
        $error("SCROLL_DIV must be at least 1");
    end
    if (TILE < 1 || (TILE & (TILE - 1)) != 0) begin : g_bad_tile
        $error("TILE must be a power of two");
    end
    if (N_ITEMS < 2 || N_ITEMS > 16) begin : g_bad_items
        $error("N_ITEMS must be within 2..16");
    end

    logic          vblnk_q;
    logic          tick;
    logic [OW-1:0] offset;

    assign tick = in.vblnk & ~vblnk_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) vblnk_q <= 1'b0;
        else     vblnk_q <= in.vblnk;
    end

`ifdef MENU_SCROLL_EN
    localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [FW-1:0] F_LAST = FW'(SCROLL_DIV - 1);

    logic [FW-1:0] frame_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= '0;
            offset    <= '0;
        end else if (tick) begin
            if (frame_cnt == F_LAST) begin
                frame_cnt <= '0;
                offset    <= offset + OW'(1);
            end else begin
                frame_cnt <= frame_cnt + FW'(1);
            end
        end
    end
`else
    assign offset = '0;
`endif

    menu_sel_ctrl #(
        .N_ITEMS (N_ITEMS)
    ) u_sel (
        .clk         (clk),
        .rst         (rst),
        .tick        (tick),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .sel_idx     (sel_idx),
        .sel_changed (sel_changed)
    );

    logic [OW-1:0] ph_h, ph_v;
    logic          grn_h, grn_v;
    logic [CW-1:0] vc, band_lo, band_hi;
    logic          in_band;
    logic          b_top, b_bot, b_lft, b_rgt;
    logic [11:0]   rgb_nxt;

    always_comb begin
        // Phase wraps naturally: 2*TILE is a power of two.
        ph_h  = OW'(in.hcount) + offset;
        ph_v  = OW'(in.vcount) + offset;
        grn_h = ph_h >= TILE_V;
        grn_v = ph_v >= TILE_V;

        b_top = in.vcount < LO_EDGE;
        b_bot = in.vcount >= BOT_EDGE;
        b_lft = in.hcount < LO_EDGE;
        b_rgt = in.hcount >= RGT_EDGE;

        vc      = CW'(in.vcount);
        band_lo = CW'(ITEM_Y0) + CW'(sel_idx) * CW'(ITEM_H);
        band_hi = band_lo + CW'(ITEM_H);
        in_band = (vc >= band_lo) && (vc < band_hi) &&
                  !b_lft && !b_rgt;

        rgb_nxt = MENU_BG_COLOR;
        if (in.vblnk || in.hblnk) rgb_nxt = COLOR_BLACK;
        else if (in.rgb != 12'h000) rgb_nxt = in.rgb;
        else if (b_top) rgb_nxt = border_color(grn_h);
        else if (b_bot) rgb_nxt = border_color(~grn_h);
        else if (b_lft) rgb_nxt = border_color(grn_v);
        else if (b_rgt) rgb_nxt = border_color(~grn_v);
        else if (in_band) rgb_nxt = COLOR_MENU_SEL;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out.vcount <= '0;
            out.vsync  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.hcount <= '0;
            out.hsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.vcount <= in.vcount;
            out.vsync  <= in.vsync;
            out.vblnk  <= in.vblnk;
            out.hcount <= in.hcount;
            out.hsync  <= in.hsync;
            out.hblnk  <= in.hblnk;
            out.rgb    <= rgb_nxt;
        end
    end

endmodule

// File: tb/tb_draw_menu_anim.sv
// Bench for draw_menu_anim: directed steps plus random pixels/buttons
// against a behavioural model of colours, frame ticks and selection.
module tb_draw_menu_anim;
    import vga_pkg::*;

    localparam int BW   = 16;
    localparam int TILE = 16;
    localparam int N    = 4;
    localparam int Y0   = 200;
    localparam int IH   = 64;
    localparam int SDIV = 4;
`ifdef MENU_SCROLL_EN
    localparam bit SCR = 1'b1;
`else
    localparam bit SCR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [1:0] sel_idx;
    logic       sel_changed;

    vga_if vin ();
    vga_if vout ();

    draw_menu_anim #(
        .BORDER_W   (BW),
        .TILE       (TILE),
        .N_ITEMS    (N),
        .ITEM_Y0    (Y0),
        .ITEM_H     (IH),
        .SCROLL_DIV (SDIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (vin),
        .out         (vout),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .sel_idx     (sel_idx),
        .sel_changed (sel_changed)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Model state: selection, pending direction (-1 up, +1 down, 0 none),
    // previous vblnk and number of frame ticks since reset.
    int m_sel = 0;
    int m_pend = 0;
    int m_ticks = 0;
    bit m_pvb = 0;

    function automatic int m_off();
        return SCR ? (m_ticks / SDIV) % (2 * TILE) : 0;
    endfunction

    function automatic logic [11:0] pat(int coord, int off, bit inv);
        bit g;
        g = ((coord + off) % (2 * TILE)) >= TILE;
        if (inv) g = !g;
        return g ? COLOR_DARK_GREEN : COLOR_DARK_BROWN;
    endfunction

    function automatic logic [11:0] m_rgb(int h, int v, logic [11:0] c,
                                          logic hb, logic vb);
        int off;
        off = m_off();
        if (hb || vb) return 12'h000;
        if (c != 12'h000) return c;
        if (v < BW) return pat(h, off, 0);
        if (v >= VER_PIXELS - BW) return pat(h, off, 1);
        if (h < BW) return pat(v, off, 0);
        if (h >= HOR_PIXELS - BW) return pat(v, off, 1);
        if (v >= Y0 + m_sel * IH && v < Y0 + (m_sel + 1) * IH)
            return COLOR_MENU_SEL;
        return MENU_BG_COLOR;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic m_reset();
        m_sel = 0;
        m_pend = 0;
        m_ticks = 0;
        m_pvb = 0;
    endtask

    // One clock: drive a pixel and buttons, step the model, check outputs.
    task automatic cyc(input string tag, input int h, input int v,
                       input logic [11:0] c, input logic hb,
                       input logic vb, input logic u, input logic d);
        logic [11:0] er;
        logic        hs, vs;
        bit          tk, ch;
        int          dir;
        er = m_rgb(h, v, c, hb, vb);
        hs = 1'($urandom);
        vs = 1'($urandom);
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hsync = hs;
        vin.vsync = vs;
        vin.hblnk = hb;
        vin.vblnk = vb;
        vin.rgb = c;
        btn_up = u;
        btn_down = d;
        tk = vb && !m_pvb;
        m_pvb = vb;
        ch = 0;
        if (tk) begin
            m_ticks++;
            if (m_pend != 0) begin
                m_sel = (m_sel + m_pend + N) % N;
                m_pend = 0;
                ch = 1;
            end
        end
        if (u != d) begin
            dir = u ? -1 : 1;
            if (m_pend == 0) m_pend = dir;
            else if (m_pend != dir) m_pend = 0;
        end
        @(posedge clk);
        #1;
        chk({tag, ".rgb"}, 32'(vout.rgb), 32'(er));
        chk({tag, ".timing"},
            32'({vout.hcount, vout.vcount, vout.hsync,
                 vout.vsync, vout.hblnk, vout.vblnk}),
            32'({11'(h), 11'(v), hs, vs, hb, vb}));
        chk({tag, ".sel_idx"}, 32'(sel_idx), 32'(m_sel));
        chk({tag, ".sel_changed"}, 32'(sel_changed), 32'(ch));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".timing"},
            32'({vout.hcount, vout.vcount, vout.hsync,
                 vout.vsync, vout.hblnk, vout.vblnk}), 32'(0));
        chk({tag, ".rgb"}, 32'(vout.rgb), 32'(0));
        chk({tag, ".sel"}, 32'({sel_idx, sel_changed}), 32'(0));
    endtask

    task automatic do_reset();
        btn_up = 1'b0;
        btn_down = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        #1;
        rst = 1'b0;
        m_reset();
    endtask

    task automatic tick_pair();
        cyc("tk1", 400, 0, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("tk0", 400, 1, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    int rh, rv;
    logic [11:0] rc;
    logic rhb, rvb, ru, rd;

    initial begin
        vin.hcount = 11'd5;
        vin.vcount = 11'd7;
        vin.hsync = 1'b1;
        vin.vsync = 1'b1;
        vin.hblnk = 1'b0;
        vin.vblnk = 1'b0;
        vin.rgb = 12'hABC;
        do_reset();

        // Border colours and priority, blank and overlay.
        cyc("top_grn", 20, 5, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("top_brn", 5, 5, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("bot_inv", 20, VER_PIXELS - 1, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("left", 3, 300, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("right", HOR_PIXELS - 1, 300, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("overlay", 300, 300, 12'hF00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("hblank", 300, 300, 12'hF00, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("bg", 300, 100, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Up from 0 wraps to last item on the next tick.
        cyc("up", 300, 100, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("wait", 300, 100, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("tick", 300, 100, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("after", 300, 100, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("band391", 300, 391, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("band392", 300, 392, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("band455", 300, 455, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("band456", 300, 456, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("band_lft", 15, 400, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Cancel, simultaneous press, repeat press, press on tick.
        cyc("c_up", 300, 100, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("c_dn", 300, 100, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1);
        tick_pair();
        cyc("both", 300, 100, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1);
        tick_pair();
        cyc("d1", 300, 100, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc("d2", 300, 100, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1);
        tick_pair();
        cyc("u1", 300, 100, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc("tk_dn", 300, 100, 12'h000, 1'b0, 1'b1, 1'b0, 1'b1);
        cyc("idle", 300, 100, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick_pair();

`ifdef MENU_SCROLL_EN
        do_reset();
        repeat (4) tick_pair();
        cyc("scroll1", 15, 5, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (124) tick_pair();
        cyc("scroll_wrap", 15, 5, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        // Random pixels, blanking, frame ticks and buttons.
        rvb = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rh = int'($urandom_range(0, HOR_PIXELS - 1));
            rv = int'($urandom_range(0, VER_PIXELS - 1));
            rc = ($urandom_range(0, 1) == 0) ? 12'h000 : 12'($urandom);
            rhb = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 9) == 0) rvb = !rvb;
            ru = ($urandom_range(0, 9) == 0);
            rd = ($urandom_range(0, 9) == 0);
            cyc("rand", rh, rv, rc, rhb, rvb, ru, rd);
        end

        // Async reset mid-line with a pending down request.
        cyc("pre0", 300, 300, 12'hF00, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("pre1", 300, 300, 12'hF00, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("pend_dn", 300, 300, 12'hF00, 1'b1, 1'b1, 1'b0, 1'b1);
        cyc("lit", 300, 300, 12'hF00, 1'b0, 1'b0, 1'b0, 1'b0);
        btn_down = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        m_reset();
        cyc("post0", 300, 300, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc("post_tk", 300, 300, 12'h000, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc("post1", 300, 210, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/draw_menu_anim.md
DRAW_MENU_ANIM -- requirements
Module: draw_menu_anim

Interface
REQ-001 Parameters, one per line: name, default, meaning. All SHALL be honoured.
- BORDER_W, 16, border thickness in pixels.
- TILE, 16, half-period of the two-colour border pattern; power of two.
- N_ITEMS, 4, number of selectable menu items (2..16).
- ITEM_Y0, 200, first row of item 0.
- ITEM_H, 64, height of one item band in pixels.
- SCROLL_DIV, 4, frames per one-pixel pattern shift (>=1).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, pixel clock.
- rst, in, 1, asynchronous active-high reset.
- in, vga_if.in, -, upstream timing and rgb.
- out, vga_if.out, -, downstream timing and rgb.
- btn_up, in, 1, single-cycle pulse: move selection up.
- btn_down, in, 1, single-cycle pulse: move selection down.
- sel_idx, out, $clog2(N_ITEMS), current selected item.
- sel_changed, out, 1, one-cycle pulse when sel_idx updates.

Function
REQ-003 All vga_if timing fields SHALL appear on out exactly 1 clk after in; rgb SHALL share that latency.
REQ-004 Blanking (in.vblnk or in.hblnk) SHALL give rgb 12'h000.
REQ-005 Non-blank pixel with in.rgb != 0 SHALL pass in.rgb unchanged (overlay transparency).
REQ-006 Non-blank pixel with in.rgb == 0: colour priority is top, bottom, left, right border, then highlight band, then MENU_BG_COLOR.
REQ-007 Borders: top vcount<BORDER_W; bottom vcount>=VER_PIXELS-BORDER_W; left hcount<BORDER_W; right hcount>=HOR_PIXELS-BORDER_W.
REQ-008 Pattern phase p = (coord + offset) & (2*TILE-1), where coord is hcount for top/bottom and vcount for left/right; p>=TILE gives COLOR_DARK_GREEN, otherwise COLOR_DARK_BROWN.
REQ-009 Bottom and right borders SHALL invert the REQ-008 colour choice.
REQ-010 Frame tick SHALL be the rising edge of in.vblnk, detected with a registered copy of in.vblnk.
REQ-011 On each tick, frame_cnt SHALL increment. When frame_cnt reaches SCROLL_DIV-1, it SHALL wrap to 0 and offset SHALL increment modulo 2*TILE.
REQ-012 Selection FSM states:
- IDLE --btn_up--> PEND_UP; IDLE --btn_down--> PEND_DN.
- PEND_UP --btn_down--> IDLE (cancel); PEND_DN --btn_up--> IDLE (cancel).
- A repeated press of the same direction SHALL be ignored.
- btn_up and btn_down in the same cycle SHALL be ignored in every state.
REQ-013 On a frame tick in PEND_UP or PEND_DN:
- sel_idx SHALL be updated: up from 0 wraps to N_ITEMS-1; down from N_ITEMS-1 wraps to 0.
- sel_changed SHALL pulse for that cycle.
- The FSM SHALL return to IDLE.
- A button in the tick cycle SHALL be evaluated against IDLE.
REQ-014 Highlight band:
- Rows: ITEM_Y0+sel_idx*ITEM_H <= vcount < ITEM_Y0+(sel_idx+1)*ITEM_H.
- Columns: BORDER_W <= hcount < HOR_PIXELS-BORDER_W.
- Colour: COLOR_MENU_SEL.
- Multiplier width SHALL hold N_ITEMS*ITEM_H without overflow.

Reset
REQ-015 While rst is asserted, the following SHALL be 0 and the FSM SHALL be IDLE:
- every out field;
- sel_idx, sel_changed;
- frame_cnt, offset, the registered vblnk copy.
REQ-016 Reset mid-frame SHALL discard a pending request. The first tick after release SHALL count as a normal tick.

Configuration
REQ-017 Macro MENU_SCROLL_EN:
- Defined: offset animates per REQ-011.
- Undefined: offset is constant 0 and frame_cnt is not synthesised. Selection still applies on the frame tick.

Structure
REQ-018 vga_pkg SHALL hold COLOR_MENU_SEL alongside the existing HOR_PIXELS, VER_PIXELS, MENU_BG_COLOR and colour constants. The FSM state enum typedef SHALL also live in vga_pkg.
REQ-019 The FSM and sel_idx/sel_changed logic SHALL be sub-module menu_sel_ctrl (clk, rst, tick, btn_up, btn_down, sel_idx, sel_changed). The pixel datapath stays in draw_menu_anim.

Verification
REQ-020 Pixel colours with defaults, MENU_SCROLL_EN undefined:
- vcount=5, hcount=20, in.rgb=0 -> out.rgb=COLOR_DARK_GREEN one clk later.
- hcount=5 at the same vcount -> COLOR_DARK_BROWN.
REQ-021 Bottom/right inversion: vcount=VER_PIXELS-1, hcount=20 -> COLOR_DARK_BROWN.
REQ-022 Overlay and blanking:
- in.rgb=12'hF00 at (300,300) -> out.rgb=12'hF00.
- in.hblnk=1 -> out.rgb=12'h000.
REQ-023 Selection:
- sel_idx=0, btn_up pulse, then tick -> sel_idx=3 and sel_changed high one cycle; highlight rows 392..455.
- btn_up then btn_down before the tick -> no change.
REQ-024 MENU_SCROLL_EN defined, SCROLL_DIV=4: after 4 ticks offset=1 and pixel (5,15) turns COLOR_DARK_GREEN; after 128 ticks offset wraps to 0.
REQ-025 rst asserted mid-line with a pending btn_down -> all outputs 0 immediately (async); after release, a tick leaves sel_idx=0.
